// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD card command-line engine behind a small Avalon-MM slave.
//
// A CMD register write launches one command frame on the SD CMD line,
// optionally collects a 48-bit response, then idles the bus for eight sd_clk
// cycles before reporting completion.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        register select: 0 ARG, 1 CMD/STATUS, 2 RESP arg, 3 RESP hdr/CRC
//   chipselect, write_n Avalon slave select and active-low write strobe
//   writedata[31:0]     Avalon write data
//   readdata[31:0]      registered read data (one-cycle latency, no side effects)
//   sd_clk              SD card clock, low while idle
//   bidir_port          SD CMD line, released to Z whenever the engine is not sending
//
// Build option: define SD_CMD_RESP_CRC_CHECK_EN to check the CRC7 of received
// responses and flag crc_err; otherwise crc_err reads 0 and no checker is built.

module sd_cmd_engine #(
  parameter int unsigned CLK_DIV      = 125,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  inout  wire         bidir_port
);

  localparam logic [7:0]    DivLast = 8'(CLK_DIV - 1);
  localparam int unsigned   ToW     = $clog2(RESP_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWait, StRecv, StGap} state_e;

  state_e          state_q;
  logic [7:0]      div_cnt_q;
  logic            sd_clk_q;
  logic [31:0]     arg_q;
  logic            resp_en_q;
  logic [39:0]     tx_sr_q;
  logic [6:0]      crc_q;
  logic [5:0]      bit_cnt_q;
  logic [ToW-1:0]  wait_cnt_q;
  logic [45:0]     rx_sr_q;
  logic [47:1]     resp_q;     // end bit is not kept
  logic            done_q;
  logic            timeout_q;
  logic            cmd_oe_q;
  logic            cmd_out_q;
  logic [31:0]     readdata_q;
  logic [31:0]     rd_mux;

  logic busy;
  logic tick;
  logic fall_tick;
  logic rise_tick;
  logic wr_en;
  logic cmd_in;
  logic crc_err;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic crc_err_q;
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  assign busy      = (state_q != StIdle);
  assign tick      = busy && (div_cnt_q == DivLast);
  assign fall_tick = tick && sd_clk_q;
  assign rise_tick = tick && !sd_clk_q;
  assign wr_en     = chipselect && !write_n;
  assign cmd_in    = bidir_port;

  assign bidir_port = cmd_oe_q ? cmd_out_q : 1'bz;
  assign sd_clk     = sd_clk_q;
  assign readdata   = readdata_q;

  always_comb begin
    rd_mux = 32'h0;
    unique case (address)
      2'd0: rd_mux = arg_q;
      2'd1: rd_mux = {28'h0, crc_err, timeout_q, done_q, busy};
      2'd2: rd_mux = resp_q[39:8];
      2'd3: rd_mux = {17'h0, resp_q[47:40], resp_q[7:1]};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      div_cnt_q  <= 8'h0;
      sd_clk_q   <= 1'b0;
      arg_q      <= 32'h0;
      resp_en_q  <= 1'b0;
      tx_sr_q    <= 40'h0;
      crc_q      <= 7'h0;
      bit_cnt_q  <= 6'h0;
      wait_cnt_q <= '0;
      rx_sr_q    <= 46'h0;
      resp_q     <= 47'h0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cmd_oe_q   <= 1'b0;
      cmd_out_q  <= 1'b1;
      readdata_q <= 32'h0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
      crc_err_q  <= 1'b0;
`endif
    end else begin
      readdata_q <= rd_mux;

      // sd_clk divider runs only during a transaction; the GAP exit lands on a
      // fall tick, so the clock is already low when busy drops.
      if (!busy) begin
        div_cnt_q <= 8'h0;
        sd_clk_q  <= 1'b0;
      end else if (tick) begin
        div_cnt_q <= 8'h0;
        sd_clk_q  <= ~sd_clk_q;
      end else begin
        div_cnt_q <= div_cnt_q + 8'h1;
      end

      unique case (state_q)
        StIdle: begin
          if (wr_en && (address == 2'd0)) begin
            arg_q <= writedata;
          end
          if (wr_en && (address == 2'd1)) begin
            resp_en_q <= writedata[6];
            tx_sr_q   <= {2'b01, writedata[5:0], arg_q};
            crc_q     <= 7'h0;
            bit_cnt_q <= 6'h0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            crc_err_q <= 1'b0;
`endif
            state_q   <= StSend;
          end
        end

        // bit_cnt 0..39: header+arg, 40..46: CRC7, 47: end bit, 48: release.
        StSend: begin
          if (fall_tick) begin
            bit_cnt_q <= bit_cnt_q + 6'h1;
            if (bit_cnt_q < 6'd40) begin
              cmd_oe_q  <= 1'b1;
              cmd_out_q <= tx_sr_q[39];
              tx_sr_q   <= {tx_sr_q[38:0], 1'b0};
              crc_q     <= crc7_step(crc_q, tx_sr_q[39]);
            end else if (bit_cnt_q < 6'd47) begin
              cmd_out_q <= crc_q[6];
              crc_q     <= {crc_q[5:0], 1'b0};
            end else if (bit_cnt_q == 6'd47) begin
              cmd_out_q <= 1'b1;
            end else begin
              cmd_oe_q   <= 1'b0;
              cmd_out_q  <= 1'b1;
              bit_cnt_q  <= 6'h0;
              wait_cnt_q <= '0;
              crc_q      <= 7'h0;
              state_q    <= resp_en_q ? StWait : StGap;
            end
          end
        end

        StWait: begin
          if (rise_tick) begin
            if (!cmd_in) begin
              bit_cnt_q <= 6'h0;
              state_q   <= StRecv;
            end else if (wait_cnt_q == ToLast) begin
              timeout_q <= 1'b1;
              bit_cnt_q <= 6'h0;
              state_q   <= StGap;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end

        // Start bit already seen; bit_cnt n lands in RESP[46-n], n = 46 is the end bit.
        StRecv: begin
          if (rise_tick) begin
            rx_sr_q   <= {rx_sr_q[44:0], cmd_in};
            bit_cnt_q <= bit_cnt_q + 6'h1;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            if (bit_cnt_q < 6'd39) begin
              crc_q <= crc7_step(crc_q, cmd_in);
            end
`endif
            if (bit_cnt_q == 6'd46) begin
              resp_q    <= {1'b0, rx_sr_q};
              bit_cnt_q <= 6'h0;
              state_q   <= StGap;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
              crc_err_q <= (crc_q != rx_sr_q[6:0]);
`endif
            end
          end
        end

        // Count eight sd_clk rising edges, then finish on the following fall.
        StGap: begin
          if (rise_tick && (bit_cnt_q != 6'd8)) begin
            bit_cnt_q <= bit_cnt_q + 6'h1;
          end
          if (fall_tick && (bit_cnt_q == 6'd8)) begin
            bit_cnt_q <= 6'h0;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        sd_clk;
  wire         sd_cmd;

  logic card_oe = 1'b0;
  logic card_bit = 1'b1;
  logic card_kill = 1'b0;
  int   card_mode = 0;  // 0 silent, 1 valid response, 2 response with one CRC bit flipped

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_frame_q[$];

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  localparam logic ExpCrcErr = 1'b1;
`else
  localparam logic ExpCrcErr = 1'b0;
`endif

  pullup (sd_cmd);
  assign sd_cmd = card_oe ? card_bit : 1'bz;

  always #5 clk = ~clk;

  sd_cmd_engine #(
    .CLK_DIV      (2),
    .RESP_TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .bidir_port (sd_cmd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = 7'h0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] frame48(input logic dir, input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] h;
    h = {1'b0, dir, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  // Card model: captures each host frame, scores it, and optionally answers.
  initial begin
    logic [47:0] frame;
    logic [47:0] resp;
    logic aborted;
    forever begin
      @(posedge sd_clk);
      if (!card_oe && sd_cmd === 1'b0) begin
        frame = 48'h0;
        for (int i = 0; i < 47; i++) begin
          @(posedge sd_clk);
          frame = {frame[46:0], sd_cmd};
        end
        if (exp_frame_q.size() == 0) check("frame_extra", exp_frame_q.size(), 1);
        else check("frame", frame, exp_frame_q.pop_front());
        if (card_mode != 0) begin
          resp = frame48(1'b0, frame[45:40], frame[39:8]);
          if (card_mode == 2) resp[1] = ~resp[1];
          aborted = 1'b0;
          for (int k = 0; k < 4 && !aborted; k++) begin
            @(negedge sd_clk or posedge card_kill);
            if (card_kill) aborted = 1'b1;
          end
          for (int i = 47; i >= 0 && !aborted; i--) begin
            @(negedge sd_clk or posedge card_kill);
            if (card_kill) aborted = 1'b1;
            else begin
              card_bit = resp[i];
              card_oe  = 1'b1;
            end
          end
          if (!aborted) @(negedge sd_clk or posedge card_kill);
          card_oe  = 1'b0;
          card_bit = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  // Runs one command; rises counts sd_clk rising edges from the start bit until busy drops.
  task automatic run_cmd(input logic [31:0] arg, input logic [7:0] cmd, input int mode,
                         input bit inject, output int rises);
    bit started, finished, prev;
    int inj;
    logic [1:0] addr_prev;
    card_mode = mode;
    av_write(2'd0, arg);
    exp_frame_q.push_back(frame48(1'b1, cmd[5:0], arg));
    av_write(2'd1, {24'h0, cmd});
    started = 0; finished = 0; rises = 0; prev = sd_clk; inj = 0; addr_prev = address;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (sd_clk && !prev && started) rises++;
      prev = sd_clk;
      if (sd_cmd === 1'b0) started = 1;
      if (addr_prev == 2'd1 && started && inj != 1 && inj != 2 && readdata[0] == 1'b0) begin
        finished = 1;
        break;
      end
      if (inject && rises == 10 && inj == 0) begin
        address = 2'd0; writedata = 32'hFFFF_FFFF; chipselect = 1'b1; write_n = 1'b0; inj = 1;
      end else if (inj == 1) begin
        address = 2'd1; writedata = 32'h41; inj = 2;
      end else if (inj == 2) begin
        chipselect = 1'b0; write_n = 1'b1; inj = 3;
      end
      addr_prev = address;
    end
    check("done_wait", finished, 1);
  endtask

  initial begin
    logic [31:0] d;
    logic [47:0] r;
    int rises;

    repeat (3) @(negedge clk);
    check("rst_sd_clk", sd_clk, 0);
    check("rst_readdata", readdata, 0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      av_read(2'(a), d);
      check($sformatf("rst_reg%0d", a), d, 0);
    end

    // CMD0, no response
    run_cmd(32'h0, 8'h00, 0, 0, rises);
    check("cmd0_rises", rises, 56);
    av_read(2'd1, d); check("cmd0_status", d, 32'h2);

    // CMD8 with a valid R7 reply
    r = frame48(1'b0, 6'd8, 32'h1AA);
    run_cmd(32'h1AA, 8'h48, 1, 0, rises);
    check("cmd8_rises", rises, 108);
    av_read(2'd1, d); check("cmd8_status", d, 32'h2);
    av_read(2'd2, d); check("cmd8_resp_arg", d, r[39:8]);
    av_read(2'd3, d); check("cmd8_resp_hdr", d, {17'h0, r[47:40], r[7:1]});

    // Silent card: timeout, response registers untouched
    run_cmd(32'h1AA, 8'h48, 0, 0, rises);
    check("to_rises", rises, 120);
    av_read(2'd1, d); check("to_status", d, 32'h6);
    av_read(2'd2, d); check("to_resp_arg", d, r[39:8]);
    av_read(2'd3, d); check("to_resp_hdr", d, {17'h0, r[47:40], r[7:1]});

    // Writes during SEND are ignored
    run_cmd(32'h1234_5678, 8'h05, 0, 1, rises);
    check("inj_rises", rises, 56);
    av_read(2'd1, d); check("inj_status", d, 32'h2);
    av_read(2'd0, d); check("inj_arg", d, 32'h1234_5678);

    // Corrupted response CRC
    r = frame48(1'b0, 6'd8, 32'h1AA);
    r[1] = ~r[1];
    run_cmd(32'h1AA, 8'h48, 2, 0, rises);
    av_read(2'd1, d); check("crc_status", d, {28'h0, ExpCrcErr, 3'b010});
    av_read(2'd2, d); check("crc_resp_arg", d, r[39:8]);
    av_read(2'd3, d); check("crc_resp_hdr", d, {17'h0, r[47:40], r[7:1]});

    // Reset in the middle of a response
    card_mode = 1;
    av_write(2'd0, 32'hABCD);
    exp_frame_q.push_back(frame48(1'b1, 6'd8, 32'hABCD));
    av_write(2'd1, 32'h48);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (card_oe) break;
    end
    check("recv_reached", card_oe, 1);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    card_kill = 1'b1;
    #1;
    check("mid_rst_sd_clk", sd_clk, 0);
    check("mid_rst_readdata", readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    card_kill = 1'b0;
    @(negedge clk);
    check("mid_rst_line", sd_cmd, 1);
    av_read(2'd1, d); check("mid_rst_status", d, 0);
    av_read(2'd2, d); check("mid_rst_resp", d, 0);
    av_read(2'd0, d); check("mid_rst_arg", d, 0);

    run_cmd(32'h0, 8'h00, 0, 0, rises);
    check("post_rst_rises", rises, 56);
    av_read(2'd1, d); check("post_rst_status", d, 32'h2);
    check("sb_empty", exp_frame_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125, giving the number of clk cycles per sd_clk half-period (legal range 2..255).
REQ-002 The block SHALL have parameter RESP_TIMEOUT, default 64, giving the number of sd_clk rising edges to wait for a response start bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon register select.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: Avalon write strobe, active-low.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered Avalon read data.
REQ-010 The block SHALL have port sd_clk, output, 1 bit: SD card clock.
REQ-011 The block SHALL have port bidir_port, inout, 1 bit: SD CMD line, released to Z when not driven.

Function
REQ-012 Register map, read and write: addr0 = ARG[31:0] (R/W); addr1 write = CMD: [5:0] index, [6] resp_en, and a write starts a transaction; addr1 read = STATUS {28'b0, crc_err, timeout, done, busy}; addr2 read = RESP[39:8] (response argument); addr3 read = {17'b0, RESP[47:40], RESP[7:1]} (index/header byte and CRC7).
REQ-013 readdata SHALL be registered every clk cycle from the address-selected value (one-cycle latency), and reads SHALL have no side effects.
REQ-014 Writes to addr0 or addr1 while busy=1 SHALL be ignored, as SHALL writes to addr2 and addr3.
REQ-015 An addr1 write while idle SHALL set busy=1 and clear done, timeout and crc_err on the same edge.
REQ-016 sd_clk SHALL toggle every CLK_DIV clk cycles only while busy, and SHALL rest low otherwise.
REQ-017 A "fall tick" SHALL be the clk cycle in which sd_clk goes high-to-low, and a "rise tick" the cycle in which it goes low-to-high.
REQ-018 The CMD line SHALL be driven or changed only on fall ticks and sampled only on rise ticks.
REQ-019 State IDLE: bidir_port SHALL be Z; a CMD write SHALL move to SEND.
REQ-020 State SEND: the block SHALL drive 48 bits MSB-first: 0, 1, index[5:0], ARG[31:0], CRC7[6:0], 1.
REQ-021 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
REQ-022 After SEND, the block SHALL go to WAIT if resp_en=1, and to GAP otherwise.
REQ-023 State WAIT: bidir_port SHALL be Z; a sampled 0 SHALL move to RECV; RESP_TIMEOUT rise ticks without a 0 SHALL set timeout=1 and move to GAP.
REQ-024 State RECV: the block SHALL shift in the remaining 47 bits into RESP[46:0], with RESP[47]=0, and then move to GAP.
REQ-025 State GAP: bidir_port SHALL be Z for 8 sd_clk cycles; on exit the block SHALL set done=1 and busy=0 and return to IDLE.
REQ-026 RESP SHALL hold its value until the next response is received.

Reset
REQ-027 While reset_n=0, asynchronously: state=IDLE; bidir_port=Z; sd_clk=0; readdata=0; ARG=0; RESP=0; busy, done, timeout and crc_err all 0.
REQ-028 A reset asserted during any state SHALL abort the transaction with no completion flag set.

Configuration
REQ-029 With macro SD_CMD_RESP_CRC_CHECK_EN defined, in RECV the block SHALL compute CRC7 over RESP[47:8] and set crc_err=1 at GAP entry if it differs from RESP[7:1].
REQ-030 With SD_CMD_RESP_CRC_CHECK_EN undefined, no response CRC logic SHALL exist and crc_err SHALL read 0.

Verification
REQ-031 CLK_DIV=2, ARG=0, CMD write 0x00 -> line carries 0x400000000095; busy for 56 sd_clk cycles; done=1, timeout=0.
REQ-032 ARG=0x000001AA, CMD write 0x48 -> line carries 0x48000001AA87; the card model returns a valid R7 -> addr2 reads 0x000001AA; done=1; crc_err=0.
REQ-033 CMD write 0x48 with the card silent (line pulled high) -> timeout=1 after 64 rise ticks in WAIT; done=1; RESP unchanged.
REQ-034 During SEND, write ARG=0xFFFFFFFF and CMD 0x41 -> ignored: the frame completes unchanged and ARG reads back the original value.
REQ-035 With the macro defined, a card model that flips one CRC bit -> crc_err=1; with the macro undefined, crc_err=0.
REQ-036 reset_n pulsed low mid-RECV -> bidir_port=Z and sd_clk=0 immediately, all STATUS bits 0, and the next command runs normally.
